// File: rtl/risc_fetch_pkg.sv
// Shared fetch-path types and constants: XLEN, the canonical NOP and the sequential PC step.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package risc_fetch_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- shown to decode whenever no instruction is valid
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    // One prefetch queue entry: instruction word tagged with the PC it was fetched from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

    // Sequential fetch step; wraps naturally at 2^32
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; head is read straight from the storage array.
// Latency: a word pushed in cycle N is visible at the head in cycle N+1.
// Backpressure: push ignored when full unless a pop happens in the same cycle; flush wins over both.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_pop;
    logic             do_push;

    // Qualify requests: pop only when something is held, push into a full FIFO only alongside a pop
    always_comb begin
        do_pop  = pop && (cnt != '0) && !flush;
        do_push = push && ((cnt != FULL_CNT) || do_pop) && !flush;
    end

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (cnt == '0);
    assign count     = cnt;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: issues in-order word fetches and queues {PC, insn} for decode.
// Latency: request accepted in cycle N, response in N+1, Inst_Valid in N+2 at the earliest.
// Backpressure: FIFO space is reserved at issue, so Inst_Ready low stalls issue and never drops a word.
// Optional build macro FETCH_PERF_CNT_EN adds Perf_Fetched / Perf_Flushed counters.
module fetch_prefetch_queue
    import risc_fetch_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Redirect_Valid,
    input  logic [XLEN-1:0] Redirect_PC,
    output logic            Imem_Req_Valid,
    input  logic            Imem_Req_Ready,
    output logic [XLEN-1:0] Imem_Req_Addr,
    input  logic            Imem_Rsp_Valid,
    input  logic [XLEN-1:0] Imem_Rsp_Data,
    output logic            Inst_Valid,
    input  logic            Inst_Ready,
    output logic [XLEN-1:0] Inst_Data,
    output logic [XLEN-1:0] Inst_PC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     Perf_Fetched,
    output logic [31:0]     Perf_Flushed
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] MAX_OS  = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   drop_q;

    // PCs of issued requests whose responses will be kept, in issue order
    logic [XLEN-1:0] shadow_q [DEPTH];
    logic [AW-1:0]   sh_wr_q;
    logic [AW-1:0]   sh_rd_q;

    logic            req_vld;
    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic            inst_vld;
    logic [CW:0]     reserved;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Only the word-aligned part of a redirect target is meaningful
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^Redirect_PC[1:0];

    // Issue gating, response classification and decode handshake
    always_comb begin
        reserved  = {1'b0, outstanding_q} + {1'b0, fifo_count};
        req_vld   = !Reset && !Redirect_Valid && (outstanding_q < MAX_OS) && (reserved < DEPTH_C);
        req_fire  = req_vld && Imem_Req_Ready;
        // Responses with nothing outstanding belong to traffic abandoned by reset
        rsp_fire  = !Reset && Imem_Rsp_Valid && (|outstanding_q);
        // A response racing a redirect is stale as well
        rsp_drop  = rsp_fire && ((|drop_q) || Redirect_Valid);
        push      = rsp_fire && !rsp_drop;
        inst_vld  = !Reset && !Redirect_Valid && !fifo_empty;
        pop       = inst_vld && Inst_Ready;
        push_entry.pc   = shadow_q[sh_rd_q];
        push_entry.insn = Imem_Rsp_Data;
    end

    // Fetch PC, outstanding/drop accounting and shadow queue pointers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            sh_wr_q       <= '0;
            sh_rd_q       <= '0;
        end else begin
            outstanding_q <= outstanding_q + CW'(req_fire) - CW'(rsp_fire);
            if (Redirect_Valid) begin
                // Everything still in flight after this cycle is stale
                pc_q    <= {Redirect_PC[XLEN-1:2], 2'b00};
                drop_q  <= outstanding_q - CW'(rsp_fire);
                sh_wr_q <= '0;
                sh_rd_q <= '0;
            end else begin
                if (req_fire) begin
                    pc_q    <= pc_next(pc_q);
                    sh_wr_q <= sh_wr_q + AW'(1);
                end
                if (rsp_drop) drop_q  <= drop_q - CW'(1);
                if (push)     sh_rd_q <= sh_rd_q + AW'(1);
            end
        end
    end

    // Capture the PC of each accepted request for tagging its response
    always_ff @(posedge Clk) begin
        if (req_fire) shadow_q[sh_wr_q] <= pc_q;
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .reset     (Reset),
        .flush     (Redirect_Valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Decode-facing outputs; a NOP and zero PC whenever nothing is presented
    always_comb begin
        Imem_Req_Valid = req_vld;
        Imem_Req_Addr  = pc_q;
        Inst_Valid     = inst_vld;
        Inst_Data      = inst_vld ? head.insn : NOP_INSN;
        Inst_PC        = inst_vld ? head.pc   : '0;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] flushed_q;

    // Words queued, and words thrown away (flushed entries plus dropped responses)
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            if (push) fetched_q <= fetched_q + 32'd1;
            flushed_q <= flushed_q + (Redirect_Valid ? 32'(fifo_count) : 32'd0) + 32'(rsp_drop);
        end
    end

    assign Perf_Fetched = fetched_q;
    assign Perf_Flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench: queue-level reference model checked every cycle, plus literal scenario checks.
// Latency: n/a.
// Backpressure: bench memory answers in order, one cycle or more after acceptance.
module tb_fetch_prefetch_queue;
    import risc_fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        redir;
    logic [31:0] redir_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    fetch_prefetch_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (32'h0)
    ) dut (
        .Clk            (clk),
        .Reset          (rst),
        .Redirect_Valid (redir),
        .Redirect_PC    (redir_pc),
        .Imem_Req_Valid (req_valid),
        .Imem_Req_Ready (req_ready),
        .Imem_Req_Addr  (req_addr),
        .Imem_Rsp_Valid (rsp_valid),
        .Imem_Rsp_Data  (rsp_data),
        .Inst_Valid     (inst_valid),
        .Inst_Ready     (inst_ready),
        .Inst_Data      (inst_data),
        .Inst_PC        (inst_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .Perf_Fetched   (perf_fetched),
        .Perf_Flushed   (perf_flushed)
`endif
    );

    int n_vec;
    int n_miss;
    int cyc;
    logic rsp_en;

    // Memory: accepted addresses with the cycle from which they may answer
    logic [31:0] mem_addr_q [$];
    int          mem_due_q  [$];

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_keep [$];
    int          m_drop;
    logic [63:0] m_fifo [$];
    int          m_fetched;
    int          m_flushed;

    // Observations of the DUT for the literal scenario checks
    logic [31:0] obs_req [$];
    logic [31:0] obs_pop [$];
    int          first_req;
    int          first_val;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_req(input int k, input logic [31:0] exp);
        chk("req_seq", (obs_req.size() > k) ? obs_req[k] : 32'hBAD0_BAD0, exp);
    endtask

    task automatic chk_pop(input int k, input logic [31:0] exp);
        chk("pop_seq", (obs_pop.size() > k) ? obs_pop[k] : 32'hBAD0_BAD0, exp);
    endtask

    task automatic clear_obs();
        obs_req.delete();
        obs_pop.delete();
        first_req = -1;
        first_val = -1;
    endtask

    // One clock: memory drives response, outputs are compared to the model, then all state advances
    task automatic step();
        logic        exp_rv;
        logic        exp_iv;
        logic        rsp_take;
        logic [31:0] exp_data;
        logic [31:0] exp_pc;
        logic [31:0] tag;
        int          m_out;

        if (rsp_en && (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc)) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(mem_addr_q[0]);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'hDEAD_BEEF;
        end
        #1;

        m_out    = m_drop + m_keep.size();
        exp_rv   = !rst && !redir && (m_out < MAXO) && ((m_out + m_fifo.size()) < DEPTH);
        exp_iv   = !rst && !redir && (m_fifo.size() > 0);
        exp_data = exp_iv ? m_fifo[0][31:0]  : 32'h0000_0013;
        exp_pc   = exp_iv ? m_fifo[0][63:32] : 32'h0;

        chk("req_valid", 32'(req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", req_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
        chk("inst_data", inst_data, exp_data);
        chk("inst_pc", inst_pc, exp_pc);
        if (inst_valid) chk("data_matches_pc", inst_data, mem_word(inst_pc));
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'(m_fetched));
        chk("perf_flushed", perf_flushed, 32'(m_flushed));
`endif

        if (req_valid && req_ready) begin
            obs_req.push_back(req_addr);
            if (first_req < 0) first_req = cyc;
        end
        if (inst_valid && first_val < 0) first_val = cyc;
        if (inst_valid && inst_ready) obs_pop.push_back(inst_pc);

        rsp_take = rsp_valid && (m_out > 0);
        if (rst) begin
            m_pc = 32'h0;
            m_keep.delete();
            m_fifo.delete();
            m_drop    = 0;
            m_fetched = 0;
            m_flushed = 0;
        end else if (redir) begin
            m_flushed += m_fifo.size() + (rsp_take ? 1 : 0);
            m_fifo.delete();
            m_keep.delete();
            m_drop = m_out - (rsp_take ? 1 : 0);
            m_pc   = {redir_pc[31:2], 2'b00};
        end else begin
            if (exp_iv && inst_ready) void'(m_fifo.pop_front());
            if (rsp_take) begin
                if (m_drop > 0) begin
                    m_drop--;
                    m_flushed++;
                end else begin
                    tag = m_keep.pop_front();
                    m_fifo.push_back({tag, rsp_data});
                    m_fetched++;
                end
            end
            if (exp_rv && req_ready) begin
                m_keep.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end

        if (rsp_valid) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (req_valid && req_ready) begin
            mem_addr_q.push_back(req_addr);
            mem_due_q.push_back(cyc + 1);
        end

        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_miss = 0; cyc = 0;
        rst = 1'b1; redir = 1'b0; redir_pc = 32'h0;
        req_ready = 1'b1; inst_ready = 1'b1; rsp_en = 1'b1;
        rsp_valid = 1'b0; rsp_data = 32'h0;
        m_pc = 32'h0; m_drop = 0; m_fetched = 0; m_flushed = 0;
        clear_obs();
        @(negedge clk);

        // Reset state
        run(2);
        #1;
        chk("rst_req_valid", 32'(req_valid), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_data", inst_data, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 32'h0);

        // 1: streaming, one instruction per cycle
        rst = 1'b0;
        clear_obs();
        run(12);
        chk("t1_first_latency", 32'(first_val - first_req), 32'd2);
        for (int k = 0; k < 8; k++) chk_pop(k, 32'(4 * k));
        chk("t1_pop_count", 32'(obs_pop.size()), 32'd10);

        // 2: decode stalled for 10 cycles
        rst = 1'b1; run(1); rst = 1'b0;
        inst_ready = 1'b0;
        clear_obs();
        run(10);
        #1;
        chk("t2_req_stalled", 32'(req_valid), 32'h0);
        chk("t2_head_valid", 32'(inst_valid), 32'h1);
        chk("t2_head_pc", inst_pc, 32'h0);
        chk("t2_reqs_issued", 32'(obs_req.size()), 32'd4);
        inst_ready = 1'b1;
        clear_obs();
        run(8);
        for (int k = 0; k < 5; k++) chk_pop(k, 32'(4 * k));

        // 3: redirect with two requests in flight
        rst = 1'b1; run(1); rst = 1'b0;
        rsp_en = 1'b0;
        run(3);
        #1;
        chk("t3_two_outstanding", 32'(req_valid), 32'h0);
        redir = 1'b1; redir_pc = 32'h0000_0103;
        clear_obs();
        run(1);
        redir = 1'b0; rsp_en = 1'b1;
        run(8);
        chk_req(0, 32'h0000_0100);
        chk_pop(0, 32'h0000_0100);
        chk_pop(1, 32'h0000_0104);

        // 4: redirect colliding with a response and a ready decode
        rst = 1'b1; run(1); rst = 1'b0;
        run(6);
        redir = 1'b1; redir_pc = 32'h0000_0200;
        clear_obs();
        run(1);
        chk("t4_no_pop", 32'(obs_pop.size()), 32'd0);
        redir = 1'b0;
        #1;
        chk("t4_empty_after", 32'(inst_valid), 32'h0);
        run(6);
        chk_req(0, 32'h0000_0200);
        chk_pop(0, 32'h0000_0200);

        // 5: fetch address wraps past the top of memory
        redir = 1'b1; redir_pc = 32'hFFFF_FFF8;
        clear_obs();
        run(1);
        redir = 1'b0;
        run(8);
        chk_req(0, 32'hFFFF_FFF8);
        chk_req(1, 32'hFFFF_FFFC);
        chk_req(2, 32'h0000_0000);
        chk_pop(0, 32'hFFFF_FFF8);
        chk_pop(1, 32'hFFFF_FFFC);
        chk_pop(2, 32'h0000_0000);

        // 6: reset with queued words and requests in flight; stale responses arrive after
        rst = 1'b1; run(1); rst = 1'b0;
        inst_ready = 1'b0;
        run(3);
        rsp_en = 1'b0;
        run(3);
        #1;
        chk("t6_held_valid", 32'(inst_valid), 32'h1);
        rst = 1'b1; rsp_en = 1'b1;
        run(1);
        rst = 1'b0; inst_ready = 1'b1;
        clear_obs();
`ifdef FETCH_PERF_CNT_EN
        #1;
        chk("t6_perf_fetched_zero", perf_fetched, 32'h0);
        chk("t6_perf_flushed_zero", perf_flushed, 32'h0);
`endif
        run(8);
        chk_req(0, 32'h0000_0000);
        chk_pop(0, 32'h0000_0000);
        chk_pop(1, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
